// File: rtl/workout_scheduler_pkg.sv
// Shared state encoding and display widths for the workout scheduler and its neighbours.
package workout_scheduler_pkg;

  localparam int unsigned W_WNUM = 8;
  localparam int unsigned W_TIME = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WORK = 2'd1,
    ST_REST = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // True while an interval is running and seconds are being counted.
  function automatic logic is_active(state_e s);
    return (s == ST_WORK) || (s == ST_REST);
  endfunction

endpackage

// File: rtl/workout_scheduler_if.sv
// Session control inputs and display/buzzer outputs of the workout scheduler.
interface workout_scheduler_if;
  import workout_scheduler_pkg::*;

  logic              start;
  logic              skip;
  logic [W_WNUM-1:0] total_workouts;
  logic [W_WNUM-1:0] workout_num;
  logic [W_TIME-1:0] time_remain;
  logic              phase;
  logic              busy;
  logic              done;
  logic              buzzer;

  modport master (
    output start, skip, total_workouts,
    input  workout_num, time_remain, phase, busy, done, buzzer
  );

  modport slave (
    input  start, skip, total_workouts,
    output workout_num, time_remain, phase, busy, done, buzzer
  );

endinterface

// File: rtl/workout_scheduler_sec_tick_gen.sv
// One-second prescaler: counts while enabled, single-cycle tick on the last count, sync clear.
module sec_tick_gen #(
  parameter int unsigned CLK_PER_SEC = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_c_o
);

  localparam int unsigned W_CNT = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [W_CNT-1:0] CNT_MAX = W_CNT'(CLK_PER_SEC - 1);

  logic [W_CNT-1:0] cnt_q, cnt_d;

  assign tick_c_o = en_i && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i || tick_c_o) cnt_d = '0;
    else                            cnt_d = cnt_q + W_CNT'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/workout_scheduler.sv
// Sequences one training session of alternating WORK/REST intervals with skip and buzzer.
module workout_scheduler
  import workout_scheduler_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC = 100_000_000,
  parameter int unsigned WORK_SEC    = 45,
  parameter int unsigned REST_SEC    = 15,
  parameter int unsigned BUZZ_CYCLES = 50_000_000
) (
  input  logic                clk,
  input  logic                reset,
  workout_scheduler_if.slave  bus
);

  localparam int unsigned W_BUZ = $clog2(BUZZ_CYCLES + 1);

  state_e            state_q, state_d;
  logic [W_WNUM-1:0] tot_q, tot_d;
  logic [W_WNUM-1:0] wn_q, wn_d;
  logic [W_TIME-1:0] tr_q, tr_d;
  logic              phase_q, phase_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [W_BUZ-1:0]  buzz_cnt_q, buzz_cnt_d;
  logic              buzzer_q, buzzer_d;
  logic              skip_q;

  logic tick;
  logic tick_clr;
  logic buzz_evt;
  logic skip_rise;
  logic ivl_end;

  sec_tick_gen #(.CLK_PER_SEC(CLK_PER_SEC)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .en_i     (is_active(state_q)),
    .clr_i    (tick_clr),
    .tick_c_o (tick)
  );

  // A skip edge and a final tick in the same cycle collapse into one interval end.
  assign skip_rise = bus.skip & ~skip_q;
  assign ivl_end   = is_active(state_q) && (skip_rise || (tick && (tr_q == W_TIME'(1))));

  always_comb begin
    state_d  = state_q;
    tot_d    = tot_q;
    wn_d     = wn_q;
    tr_d     = tr_q;
    buzz_evt = 1'b0;
    tick_clr = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          tot_d    = bus.total_workouts;
          tick_clr = 1'b1;
          if (bus.total_workouts == '0) begin
            state_d  = ST_DONE;
            wn_d     = '0;
            tr_d     = '0;
            buzz_evt = 1'b1;
          end else begin
            state_d = ST_WORK;
            wn_d    = W_WNUM'(1);
            tr_d    = W_TIME'(WORK_SEC);
          end
        end
      end
      ST_WORK: begin
        if (ivl_end) begin
          buzz_evt = 1'b1;
          tick_clr = 1'b1;
          if (wn_q == tot_q) begin
            state_d = ST_DONE;
            tr_d    = '0;
          end else if (REST_SEC != 0) begin
            state_d = ST_REST;
            tr_d    = W_TIME'(REST_SEC);
          end else begin
            wn_d = wn_q + W_WNUM'(1);
            tr_d = W_TIME'(WORK_SEC);
          end
        end else if (tick) begin
          tr_d = tr_q - W_TIME'(1);
        end
      end
      ST_REST: begin
        if (ivl_end) begin
          buzz_evt = 1'b1;
          tick_clr = 1'b1;
          state_d  = ST_WORK;
          wn_d     = wn_q + W_WNUM'(1);
          tr_d     = W_TIME'(WORK_SEC);
        end else if (tick) begin
          tr_d = tr_q - W_TIME'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    phase_d = (state_d == ST_WORK);
    busy_d  = is_active(state_d);
    done_d  = (state_d == ST_DONE);

    // A new event reloads the on-time, so back-to-back events extend the buzz.
    if (buzz_evt)                buzz_cnt_d = W_BUZ'(BUZZ_CYCLES);
    else if (buzz_cnt_q != '0)   buzz_cnt_d = buzz_cnt_q - W_BUZ'(1);
    else                         buzz_cnt_d = '0;
    buzzer_d = (buzz_cnt_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tot_q      <= '0;
      wn_q       <= '0;
      tr_q       <= '0;
      phase_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      buzz_cnt_q <= '0;
      buzzer_q   <= 1'b0;
      skip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tot_q      <= tot_d;
      wn_q       <= wn_d;
      tr_q       <= tr_d;
      phase_q    <= phase_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      buzz_cnt_q <= buzz_cnt_d;
      buzzer_q   <= buzzer_d;
      skip_q     <= bus.skip;
    end
  end

  assign bus.workout_num = wn_q;
  assign bus.time_remain = tr_q;
  assign bus.phase       = phase_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.buzzer      = buzzer_q;

endmodule

// File: tb/tb_workout_scheduler.sv
// Bench for workout_scheduler: directed session scenarios plus randomized run against a timeline model.
module tb_workout_scheduler;
  import workout_scheduler_pkg::*;

  localparam int CPS = 4;
  localparam int WS  = 3;
  localparam int RS  = 2;
  localparam int BZ  = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  workout_scheduler_if bus ();
  workout_scheduler_if bus0 ();

  workout_scheduler #(.CLK_PER_SEC(CPS), .WORK_SEC(WS), .REST_SEC(RS), .BUZZ_CYCLES(BZ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  workout_scheduler #(.CLK_PER_SEC(CPS), .WORK_SEC(WS), .REST_SEC(0), .BUZZ_CYCLES(BZ)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Timeline model: mode 0 idle, 1 work, 2 rest, 3 done; time left derives from cycles spent in the interval.
  int   m_mode, m_wn, m_cyc, m_tot, m_buzz;
  logic m_skip_prev;

  function automatic logic [17:0] pack(int wn, int tr, bit ph, bit bu, bit dn, bit bz);
    return {8'(wn), 6'(tr), ph, bu, dn, bz};
  endfunction

  function automatic logic [17:0] obs();
    return {bus.workout_num, bus.time_remain, bus.phase, bus.busy, bus.done, bus.buzzer};
  endfunction

  function automatic logic [17:0] obs0();
    return {bus0.workout_num, bus0.time_remain, bus0.phase, bus0.busy, bus0.done, bus0.buzzer};
  endfunction

  function automatic logic [17:0] model_vec();
    int tr;
    tr = (m_mode == 1) ? WS - m_cyc / CPS : (m_mode == 2) ? RS - m_cyc / CPS : 0;
    return pack(m_wn, tr, m_mode == 1, (m_mode == 1) || (m_mode == 2), m_mode == 3, m_buzz > 0);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_wn = 0; m_cyc = 0; m_tot = 0; m_buzz = 0; m_skip_prev = 1'b0;
  endtask

  task automatic model_edge();
    bit sk, ev;
    int len;
    sk = bus.skip && !m_skip_prev;
    m_skip_prev = bus.skip;
    ev = 1'b0;
    if (m_mode == 0 || m_mode == 3) begin
      if (bus.start) begin
        m_tot = int'(bus.total_workouts);
        m_cyc = 0;
        if (m_tot == 0) begin m_mode = 3; m_wn = 0; ev = 1'b1; end
        else begin m_mode = 1; m_wn = 1; end
      end
    end else begin
      len = ((m_mode == 1) ? WS : RS) * CPS;
      if (sk || (m_cyc + 1 >= len)) begin
        ev = 1'b1;
        m_cyc = 0;
        if (m_mode == 2) begin m_mode = 1; m_wn++; end
        else if (m_wn == m_tot) m_mode = 3;
        else if (RS > 0) m_mode = 2;
        else m_wn++;
      end else begin
        m_cyc++;
      end
    end
    if (ev) m_buzz = BZ;
    else if (m_buzz > 0) m_buzz--;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b0;  bus.skip = 1'b0;  bus.total_workouts = '0;
    bus0.start = 1'b0; bus0.skip = 1'b0; bus0.total_workouts = '0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b1; bus.skip = 1'b0; bus.total_workouts = 8'd5;
    bus0.start = 1'b1; bus0.skip = 1'b0; bus0.total_workouts = 8'd5;
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs() !== 18'h0) $display("FAIL reset: got %h expected %h", obs(), 18'h0);
    else n_pass++;
    n_checks++;
    if (obs0() !== 18'h0) $display("FAIL reset_norest: got %h expected %h", obs0(), 18'h0);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_session_basic();
    int          cyc_t[8] = '{1, 12, 13, 14, 15, 21, 33, 35};
    logic [17:0] exp_t[8];
    exp_t = '{pack(1,3,1,1,0,0), pack(1,1,1,1,0,0), pack(1,2,0,1,0,1), pack(1,2,0,1,0,1),
              pack(1,2,0,1,0,0), pack(2,3,1,1,0,1), pack(2,0,0,0,1,1), pack(2,0,0,0,1,0)};
    do_reset();
    bus.total_workouts = 8'd2; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      if (c > 1) step();
      for (int k = 0; k < 8; k++) if (cyc_t[k] == c) begin
        n_checks++;
        if (obs() !== exp_t[k]) $display("FAIL basic@%0d: got %h expected %h", c, obs(), exp_t[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_zero_total();
    logic [17:0] exp_t[3];
    exp_t = '{pack(0,0,0,0,1,1), pack(0,0,0,0,1,1), pack(0,0,0,0,1,0)};
    do_reset();
    bus.total_workouts = 8'd0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) step();
      n_checks++;
      if (obs() !== exp_t[c-1]) $display("FAIL zero_total@%0d: got %h expected %h", c, obs(), exp_t[c-1]);
      else n_pass++;
    end
  endtask

  task automatic test_skip();
    int          cyc_t[7] = '{1, 5, 6, 7, 8, 13, 14};
    logic [17:0] exp_t[7];
    exp_t = '{pack(1,3,1,1,0,0), pack(1,2,1,1,0,0), pack(1,2,0,1,0,1), pack(1,2,0,1,0,1),
              pack(1,2,0,1,0,0), pack(1,1,0,1,0,0), pack(2,3,1,1,0,1)};
    do_reset();
    bus.total_workouts = 8'd3; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (c > 1) step();
      for (int k = 0; k < 7; k++) if (cyc_t[k] == c) begin
        n_checks++;
        if (obs() !== exp_t[k]) $display("FAIL skip@%0d: got %h expected %h", c, obs(), exp_t[k]);
        else n_pass++;
      end
      if (c == 5) bus.skip = 1'b1;
    end
    bus.skip = 1'b0;
  endtask

  task automatic test_skip_tick();
    int          cyc_t[6] = '{9, 12, 13, 17, 20, 21};
    logic [17:0] exp_t[6];
    exp_t = '{pack(1,1,1,1,0,0), pack(1,1,1,1,0,0), pack(1,2,0,1,0,1),
              pack(1,1,0,1,0,0), pack(1,1,0,1,0,0), pack(2,3,1,1,0,1)};
    do_reset();
    bus.total_workouts = 8'd3; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      if (c > 1) step();
      for (int k = 0; k < 6; k++) if (cyc_t[k] == c) begin
        n_checks++;
        if (obs() !== exp_t[k]) $display("FAIL skip_tick@%0d: got %h expected %h", c, obs(), exp_t[k]);
        else n_pass++;
      end
      if (c == 12) bus.skip = 1'b1;
      if (c == 14) bus.skip = 1'b0;
    end
  endtask

  task automatic test_reset_mid_rest();
    logic [17:0] exp_v;
    do_reset();
    bus.total_workouts = 8'd2; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (14) step();
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 18'h0) $display("FAIL reset_async: got %h expected %h", obs(), 18'h0);
    else n_pass++;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.total_workouts = 8'd1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    exp_v = pack(1,3,1,1,0,0);
    n_checks++;
    if (obs() !== exp_v) $display("FAIL restart: got %h expected %h", obs(), exp_v);
    else n_pass++;
    repeat (12) step();
    exp_v = pack(1,0,0,0,1,1);
    n_checks++;
    if (obs() !== exp_v) $display("FAIL single_done: got %h expected %h", obs(), exp_v);
    else n_pass++;
  endtask

  task automatic test_ignore_midsession();
    int          cyc_t[3] = '{4, 21, 33};
    logic [17:0] exp_t[3];
    exp_t = '{pack(1,3,1,1,0,0), pack(2,3,1,1,0,1), pack(2,0,0,0,1,1)};
    do_reset();
    bus.total_workouts = 8'd2; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      if (c > 1) step();
      if (c == 3) begin bus.start = 1'b1; bus.total_workouts = 8'd9; end
      if (c == 5) bus.start = 1'b0;
      for (int k = 0; k < 3; k++) if (cyc_t[k] == c) begin
        n_checks++;
        if (obs() !== exp_t[k]) $display("FAIL ignore@%0d: got %h expected %h", c, obs(), exp_t[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_no_rest();
    int          cyc_t[6] = '{1, 12, 13, 14, 15, 25};
    logic [17:0] exp_t[6];
    exp_t = '{pack(1,3,1,1,0,0), pack(1,1,1,1,0,0), pack(2,3,1,1,0,1),
              pack(2,3,1,1,0,1), pack(2,3,1,1,0,0), pack(2,0,0,0,1,1)};
    do_reset();
    bus0.total_workouts = 8'd2; bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      if (c > 1) step();
      for (int k = 0; k < 6; k++) if (cyc_t[k] == c) begin
        n_checks++;
        if (obs0() !== exp_t[k]) $display("FAIL no_rest@%0d: got %h expected %h", c, obs0(), exp_t[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [17:0] exp_v;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      bus.start = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 5) == 0) bus.skip = ~bus.skip;
      bus.total_workouts = 8'($urandom_range(0, 3));
      step();
      exp_v = model_vec();
      n_checks++;
      if (obs() !== exp_v) $display("FAIL random@%0d: got %h expected %h", c, obs(), exp_v);
      else n_pass++;
    end
    bus.start = 1'b0;
    bus.skip  = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;  bus.skip = 1'b0;  bus.total_workouts = '0;
    bus0.start = 1'b0; bus0.skip = 1'b0; bus0.total_workouts = '0;
    model_reset();
    test_reset();
    test_session_basic();
    test_zero_total();
    test_skip();
    test_skip_tick();
    test_reset_mid_rest();
    test_ignore_midsession();
    test_no_rest();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
